// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
//   Shared definitions for the fetch-stage sequencing controller.
//   - fetch_state_t : controller state encoding (RUN / WAIT / REDIR)
//   - REG_ADDR_W_DEF: default register specifier width
//   - NOP_INSTR     : encoding of the bubble instruction (addi x0,x0,0)
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    REDIR = 2'd2
  } fetch_state_t;

  localparam int          REG_ADDR_W_DEF = 5;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

endpackage

// File: rtl/fetch_ctrl_load_use.sv
// load_use_detect
//   Combinational hazard check between the load in EX and the instruction
//   in ID. A load targeting x0 never creates a hazard.
// Ports:
//   ex_mem_read          in  EX instruction is a load
//   ex_rd                in  EX destination register
//   id_rs1 / id_rs2      in  ID source registers
//   id_use_rs1/2         in  ID instruction actually reads that source
//   load_use             out ID must wait one cycle for the load result
module load_use_detect
  import fetch_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Sequencing controller for the fetch stage. Chooses the next PC, resolves
//   load-use stalls, taken-branch flushes and instruction-memory wait states,
//   and remembers a redirect target while memory is not ready.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   imem_ready          instruction memory has data for the current PC
//   id_rs1/rs2, id_use_rs1/rs2   source operands of the ID instruction
//   ex_mem_read, ex_rd  load in EX and its destination
//   ex_branch, ex_zero, ex_target  branch resolution from EX
//   pc_plus4            sequential PC from the PC adder
//   nxt_pc, pc_mux_sel  next PC and its mux select (1 = redirect)
//   pc_stall, ifid_stall, ifid_flush, idex_flush  pipeline control
//   stall_cnt, flush_cnt  saturating event counters
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch,
  input  logic                  ex_zero,
  input  logic [WIDTH-1:0]      ex_target,
  input  logic [WIDTH-1:0]      pc_plus4,
  output logic [WIDTH-1:0]      nxt_pc,
  output logic                  pc_mux_sel,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] redir_tgt;
  logic             taken;
  logic             load_use;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .load_use    (load_use)
  );

  assign taken = (ex_branch == 1'b1) && (ex_zero == 1'b1);

  // Priority decode: reset, taken branch, pending redirect, load-use,
  // memory wait, normal sequential fetch. A taken branch outranks load-use
  // because the dependent instruction is being squashed anyway.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    redir_tgt  = target_q;
    pc_mux_sel = 1'b0;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst) begin
      pc_stall   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
    end else if (taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      if (imem_ready) begin
        pc_mux_sel = 1'b1;
        redir_tgt  = ex_target;
        state_d    = RUN;
      end else begin
        pc_stall = 1'b1;
        target_d = ex_target;
        state_d  = REDIR;
      end
    end else if (state_q == REDIR) begin
      ifid_flush = 1'b1;
      if (imem_ready) begin
        pc_mux_sel = 1'b1;
        state_d    = RUN;
      end else begin
        pc_stall = 1'b1;
      end
    end else if (load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_stall   = 1'b1;
      ifid_flush = 1'b1;
      state_d    = WAIT;
    end else begin
      state_d = RUN;
    end
  end

  assign nxt_pc = pc_mux_sel ? redir_tgt : pc_plus4;

  // State, pending target and saturating counters. Reset clears everything
  // immediately so no redirect can leak past a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      target_q  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      if (pc_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (taken && (flush_cnt != '1))
        flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
